// File: rtl/sccb_cfg_sequencer.sv
// Walks the camera init ROM and issues one SCCB byte write per entry, with NACK retry.
// Define SCCB_CFG_WATCHDOG_EN to treat a write with no wr_done within TIMEOUT_CYCLES as a NACK.
module sccb_cfg_sequencer #(
  parameter int ROM_AW         = 8,
  parameter int DELAY_CYCLES   = 1_000_000,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic              wr_req_o,
  output logic [7:0]        wr_reg_addr_o,
  output logic [7:0]        wr_reg_data_o,
  input  logic              wr_ready_i,
  input  logic              wr_done_i,
  input  logic              wr_nack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ROM_AW:0]   wr_count_o,
  output logic [3:0]        state_o
);

  // wr_req/wr_ready: a write is accepted on the clock edge where both are high; until then
  // wr_req, wr_reg_addr and wr_reg_data stay constant, and wr_req falls right after acceptance.

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT_ROM, S_DECODE, S_DELAY,
    S_ISSUE, S_WAIT_DONE, S_NEXT, S_DONE, S_ERROR
  } state_e;

  state_e            state_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic              wr_req_q;
  logic [7:0]        reg_addr_q;
  logic [7:0]        reg_data_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [ROM_AW:0]   wr_count_q;
  logic [31:0]       retry_q;
  logic [31:0]       delay_q;
  logic              timeout;
  logic              write_end;
  logic              write_fail;

`ifdef SCCB_CFG_WATCHDOG_EN
  logic [31:0] wd_q;

  assign timeout = (state_q == S_WAIT_DONE) && (wd_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wd_q <= '0;
    end else if (state_q == S_ISSUE) begin
      wd_q <= '0;
    end else if (state_q == S_WAIT_DONE) begin
      wd_q <= wd_q + 32'd1;
    end
  end
`else
  // No watchdog: constant 0 for any legal TIMEOUT_CYCLES.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // A watchdog expiry counts as a NACK; a real wr_done in the same cycle wins.
  assign write_end  = wr_done_i || timeout;
  assign write_fail = wr_done_i ? wr_nack_i : 1'b1;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      wr_req_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      wr_count_q <= '0;
      retry_q    <= '0;
      delay_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            rom_addr_q <= '0;
            wr_count_q <= '0;
            retry_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH:    state_q <= S_WAIT_ROM;
        S_WAIT_ROM: state_q <= S_DECODE;
        S_DECODE: begin
          if (rom_data_i == 16'hFFFF) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (rom_data_i == 16'hFFF0) begin
            delay_q <= 32'(DELAY_CYCLES - 1);
            state_q <= S_DELAY;
          end else begin
            reg_addr_q <= rom_data_i[15:8];
            reg_data_q <= rom_data_i[7:0];
            wr_req_q   <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_DELAY: begin
          if (delay_q == 32'd0) begin
            state_q <= S_NEXT;
          end else begin
            delay_q <= delay_q - 32'd1;
          end
        end
        S_ISSUE: begin
          if (wr_ready_i) begin
            wr_req_q <= 1'b0;
            state_q  <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (write_end) begin
            if (!write_fail) begin
              wr_count_q <= wr_count_q + (ROM_AW + 1)'(1);
              state_q    <= S_NEXT;
            end else if (retry_q < 32'(MAX_RETRY)) begin
              retry_q  <= retry_q + 32'd1;
              wr_req_q <= 1'b1;
              state_q  <= S_ISSUE;
            end else begin
              busy_q  <= 1'b0;
              error_q <= 1'b1;
              state_q <= S_ERROR;
            end
          end
        end
        S_NEXT: begin
          retry_q <= '0;
          // A table without an end marker finishes at the last address instead of wrapping.
          if (rom_addr_q == '1) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            rom_addr_q <= rom_addr_q + ROM_AW'(1);
            state_q    <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr_o    = rom_addr_q;
  assign wr_req_o      = wr_req_q;
  assign wr_reg_addr_o = reg_addr_q;
  assign wr_reg_data_o = reg_data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign wr_count_o    = wr_count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Bench for sccb_cfg_sequencer: an 8-bit-address instance for the main scenarios and a
// ROM_AW=2 instance for the no-end-marker case.
module tb_sccb_cfg_sequencer;
  localparam int DLY = 16;
  localparam int RETRY = 3;
  localparam int TMO = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_miss = 0;

  // ---------------- DUT A (ROM_AW = 8) ----------------
  logic        start_a;
  logic [7:0]  rom_addr_a;
  logic [15:0] rom_data_a;
  logic        wr_req_a;
  logic [7:0]  wra_a, wrd_a;
  logic        wr_ready_a, wr_done_a, wr_nack_a;
  logic        busy_a, done_a, error_a;
  logic [8:0]  cnt_a;
  logic [3:0]  st_a;
  logic [15:0] rom_a [256];

  sccb_cfg_sequencer #(.ROM_AW(8), .DELAY_CYCLES(DLY), .MAX_RETRY(RETRY), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start_a),
    .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a),
    .wr_req_o(wr_req_a), .wr_reg_addr_o(wra_a), .wr_reg_data_o(wrd_a),
    .wr_ready_i(wr_ready_a), .wr_done_i(wr_done_a), .wr_nack_i(wr_nack_a),
    .busy_o(busy_a), .done_o(done_a), .error_o(error_a),
    .wr_count_o(cnt_a), .state_o(st_a)
  );

  always @(posedge clk) rom_data_a <= rom_a[rom_addr_a];

  // ---------------- DUT B (ROM_AW = 2) ----------------
  logic        start_b;
  logic [1:0]  rom_addr_b;
  logic [15:0] rom_data_b;
  logic        wr_req_b;
  logic [7:0]  wra_b, wrd_b;
  logic        wr_ready_b, wr_done_b, wr_nack_b;
  logic        busy_b, done_b, error_b;
  logic [2:0]  cnt_b;
  logic [3:0]  st_b;
  logic [15:0] rom_b [4];

  sccb_cfg_sequencer #(.ROM_AW(2), .DELAY_CYCLES(DLY), .MAX_RETRY(RETRY), .TIMEOUT_CYCLES(TMO)) dut_b (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start_b),
    .rom_addr_o(rom_addr_b), .rom_data_i(rom_data_b),
    .wr_req_o(wr_req_b), .wr_reg_addr_o(wra_b), .wr_reg_data_o(wrd_b),
    .wr_ready_i(wr_ready_b), .wr_done_i(wr_done_b), .wr_nack_i(wr_nack_b),
    .busy_o(busy_b), .done_o(done_b), .error_o(error_b),
    .wr_count_o(cnt_b), .state_o(st_b)
  );

  always @(posedge clk) rom_data_b <= rom_b[rom_addr_b];

  // ---------------- scoreboard / SCCB responder for A ----------------
  logic [15:0] exp_q[$];
  int ack_dly, ack_cnt, ready_block, nacks_left;
  bit withhold;
  int accept_cnt, stall_cnt, stall_bad, req_cnt, t_done, t_fetch2, t_acc1;
  logic acc_a;
  logic [15:0] exp_a;

  initial begin : resp_a
    wr_ready_a = 1'b1; wr_done_a = 1'b0; wr_nack_a = 1'b0;
    forever begin
      @(negedge clk);
      acc_a = wr_req_a && wr_ready_a && reset_n;
      if (wr_req_a) req_cnt++;
      if (wr_done_a && t_done < 0) t_done = cyc;
      if (rom_addr_a == 8'd2 && t_fetch2 < 0) t_fetch2 = cyc;
      if (wr_req_a && !wr_ready_a) begin
        stall_cnt++;
        if (exp_q.size() == 0 || {wra_a, wrd_a} !== exp_q[0]) stall_bad++;
      end
      if (acc_a) begin
        if (t_acc1 < 0) t_acc1 = cyc;
        accept_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL sb_a: write %h accepted, none expected", {wra_a, wrd_a});
        end else begin
          exp_a = exp_q.pop_front();
          if ({wra_a, wrd_a} !== exp_a) begin
            n_miss++;
            $display("FAIL sb_a: write %h accepted, expected %h", {wra_a, wrd_a}, exp_a);
          end
        end
      end
      @(posedge clk);
      #1;
      wr_done_a = 1'b0; wr_nack_a = 1'b0;
      if (acc_a) begin
        ack_cnt = withhold ? 0 : ack_dly;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          wr_done_a = 1'b1;
          if (nacks_left > 0) begin
            wr_nack_a = 1'b1;
            nacks_left--;
          end
        end
      end
      if (wr_req_a && ready_block > 0) begin
        wr_ready_a = 1'b0;
        ready_block--;
      end else begin
        wr_ready_a = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / SCCB responder for B ----------------
  logic [15:0] expb_q[$];
  int accept_b = 0;
  int ackb = 0;
  logic acc_b;
  logic [15:0] exp_b;

  initial begin : resp_b
    wr_ready_b = 1'b1; wr_done_b = 1'b0; wr_nack_b = 1'b0;
    forever begin
      @(negedge clk);
      acc_b = wr_req_b && wr_ready_b && reset_n;
      if (acc_b) begin
        accept_b++;
        n_vec++;
        if (expb_q.size() == 0) begin
          n_miss++;
          $display("FAIL sb_b: write %h accepted, none expected", {wra_b, wrd_b});
        end else begin
          exp_b = expb_q.pop_front();
          if ({wra_b, wrd_b} !== exp_b) begin
            n_miss++;
            $display("FAIL sb_b: write %h accepted, expected %h", {wra_b, wrd_b}, exp_b);
          end
        end
      end
      @(posedge clk);
      #1;
      wr_done_b = 1'b0;
      if (acc_b) ackb = 5;
      else if (ackb > 0) begin
        ackb--;
        if (ackb == 0) wr_done_b = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    ack_dly = 20; ack_cnt = 0; ready_block = 0; nacks_left = 0; withhold = 1'b0;
    accept_cnt = 0; stall_cnt = 0; stall_bad = 0; req_cnt = 0;
    t_done = -1; t_fetch2 = -1; t_acc1 = -1;
    exp_q.delete();
  endtask

  task automatic load_rom_std();
    for (int i = 0; i < 256; i++) rom_a[i] = 16'hFFFF;
    rom_a[0] = 16'h1280; rom_a[1] = 16'hFFF0; rom_a[2] = 16'h1214; rom_a[3] = 16'hFFFF;
  endtask

  task automatic pulse_start_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic wait_end_a(input int budget);
    int n = 0;
    while (!(done_a || error_a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (!(done_a || error_a)) begin
      n_miss++;
      $display("FAIL wait_end_a: no done/error after %0d cycles", budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({wr_req_a, busy_a, done_a, error_a, cnt_a, rom_addr_a} !== 21'd0) begin
      n_miss++;
      $display("FAIL reset_outs_a: got %h want 0", {wr_req_a, busy_a, done_a, error_a, cnt_a, rom_addr_a});
    end
    n_vec++;
    if (st_a !== 4'd0 || st_b !== 4'd0) begin
      n_miss++;
      $display("FAIL reset_state: got %0d/%0d want 0/0", st_a, st_b);
    end
    n_vec++;
    if ({wr_req_b, busy_b, done_b, error_b, cnt_b, rom_addr_b} !== 9'd0) begin
      n_miss++;
      $display("FAIL reset_outs_b: got %h want 0", {wr_req_b, busy_b, done_b, error_b, cnt_b, rom_addr_b});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    clear_stats(); load_rom_std();
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1214);
    pulse_start_a();
    wait_end_a(3000);
    n_vec++;
    if ({done_a, error_a, busy_a} !== 3'b100) begin
      n_miss++; $display("FAIL basic_status: got d/e/b %b want 100", {done_a, error_a, busy_a});
    end
    n_vec++;
    if (cnt_a !== 9'd2) begin n_miss++; $display("FAIL basic_count: got %0d want 2", cnt_a); end
    n_vec++;
    if (accept_cnt != 2 || exp_q.size() != 0) begin
      n_miss++; $display("FAIL basic_accepts: got %0d left %0d want 2 left 0", accept_cnt, exp_q.size());
    end
    // wr_done -> NEXT, FETCH, WAIT_ROM, DECODE, DLY cycles of DELAY, NEXT, FETCH(addr 2).
    n_vec++;
    if (t_fetch2 - t_done != DLY + 6) begin
      n_miss++; $display("FAIL basic_delay_gap: got %0d want %0d", t_fetch2 - t_done, DLY + 6);
    end
  endtask

  task automatic test_ready_stall();
    clear_stats(); load_rom_std();
    ready_block = 50;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1214);
    pulse_start_a();
    wait_end_a(3000);
    n_vec++;
    if (stall_cnt != 50) begin n_miss++; $display("FAIL stall_cycles: got %0d want 50", stall_cnt); end
    n_vec++;
    if (stall_bad != 0) begin n_miss++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stall_bad); end
    n_vec++;
    if (accept_cnt != 2 || done_a !== 1'b1) begin
      n_miss++; $display("FAIL stall_accepts: got %0d done %b want 2 done 1", accept_cnt, done_a);
    end
  endtask

  task automatic test_retry_recover();
    clear_stats(); load_rom_std();
    nacks_left = 3;
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1214);
    pulse_start_a();
    wait_end_a(3000);
    n_vec++;
    if (accept_cnt != 5) begin n_miss++; $display("FAIL retry_accepts: got %0d want 5", accept_cnt); end
    n_vec++;
    if ({done_a, error_a} !== 2'b10 || cnt_a !== 9'd2) begin
      n_miss++; $display("FAIL retry_result: got d/e %b count %0d want 10 count 2", {done_a, error_a}, cnt_a);
    end
  endtask

  task automatic test_retry_exhaust();
    int req_snap;
    clear_stats(); load_rom_std();
    nacks_left = 4;
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h1280);
    pulse_start_a();
    wait_end_a(3000);
    n_vec++;
    if ({done_a, error_a, busy_a} !== 3'b010) begin
      n_miss++; $display("FAIL exhaust_status: got d/e/b %b want 010", {done_a, error_a, busy_a});
    end
    n_vec++;
    if (rom_addr_a !== 8'd0 || cnt_a !== 9'd0) begin
      n_miss++; $display("FAIL exhaust_addr_count: got %0d/%0d want 0/0", rom_addr_a, cnt_a);
    end
    n_vec++;
    if (accept_cnt != 4) begin n_miss++; $display("FAIL exhaust_accepts: got %0d want 4", accept_cnt); end
    req_snap = req_cnt;
    repeat (40) @(negedge clk);
    n_vec++;
    if (req_cnt != req_snap || error_a !== 1'b1) begin
      n_miss++; $display("FAIL exhaust_quiet: got %0d new req cycles error %b want 0 error 1", req_cnt - req_snap, error_a);
    end
  endtask

  task automatic test_reset_mid_pass();
    int n;
    clear_stats(); load_rom_std();
    ready_block = 1000;
    exp_q.push_back(16'h1280);
    pulse_start_a();
    n = 0;
    while (!wr_req_a && n < 50) begin @(negedge clk); n++; end
    n_vec++;
    if (wr_req_a !== 1'b1) begin n_miss++; $display("FAIL midrst_req_up: got %b want 1", wr_req_a); end
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({wr_req_a, busy_a, done_a, error_a, cnt_a, rom_addr_a} !== 21'd0) begin
      n_miss++; $display("FAIL midrst_async: got %h want 0", {wr_req_a, busy_a, done_a, error_a, cnt_a, rom_addr_a});
    end
    repeat (3) @(negedge clk);
    clear_stats();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({wr_req_a, busy_a, done_a, error_a} !== 4'd0) begin
      n_miss++; $display("FAIL midrst_idle: got %b want 0000", {wr_req_a, busy_a, done_a, error_a});
    end
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1214);
    pulse_start_a();
    n_vec++;
    if (rom_addr_a !== 8'd0 || busy_a !== 1'b1) begin
      n_miss++; $display("FAIL midrst_restart: got addr %0d busy %b want 0 1", rom_addr_a, busy_a);
    end
    n = 0;
    while (accept_cnt < 1 && n < 100) begin @(negedge clk); n++; end
    pulse_start_a();
    wait_end_a(3000);
    n_vec++;
    if (accept_cnt != 2 || cnt_a !== 9'd2 || done_a !== 1'b1) begin
      n_miss++; $display("FAIL busy_start_ignored: got %0d accepts count %0d done %b want 2 2 1", accept_cnt, cnt_a, done_a);
    end
  endtask

  task automatic test_no_end_marker();
    int n;
    rom_b[0] = 16'h1101; rom_b[1] = 16'h1202; rom_b[2] = 16'h1303; rom_b[3] = 16'h1404;
    expb_q.delete();
    for (int i = 0; i < 4; i++) expb_q.push_back(rom_b[i]);
    accept_b = 0;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    n = 0;
    while (!(done_b || error_b) && n < 1000) begin @(negedge clk); n++; end
    n_vec++;
    if ({done_b, error_b} !== 2'b10) begin n_miss++; $display("FAIL noend_status: got d/e %b want 10", {done_b, error_b}); end
    n_vec++;
    if (rom_addr_b !== 2'd3 || cnt_b !== 3'd4) begin
      n_miss++; $display("FAIL noend_addr_count: got %0d/%0d want 3/4", rom_addr_b, cnt_b);
    end
    n_vec++;
    if (accept_b != 4 || expb_q.size() != 0) begin
      n_miss++; $display("FAIL noend_accepts: got %0d left %0d want 4 left 0", accept_b, expb_q.size());
    end
    repeat (10) @(negedge clk);
    n_vec++;
    if (rom_addr_b !== 2'd3 || busy_b !== 1'b0 || accept_b != 4) begin
      n_miss++; $display("FAIL noend_nowrap: got addr %0d busy %b accepts %0d want 3 0 4", rom_addr_b, busy_b, accept_b);
    end
  endtask

`ifdef SCCB_CFG_WATCHDOG_EN
  task automatic test_watchdog();
    clear_stats(); load_rom_std();
    withhold = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(16'h1280);
    pulse_start_a();
    wait_end_a(3000);
    n_vec++;
    if ({done_a, error_a} !== 2'b01 || accept_cnt != 4 || cnt_a !== 9'd0) begin
      n_miss++; $display("FAIL wdog_result: got d/e %b accepts %0d count %0d want 01 4 0", {done_a, error_a}, accept_cnt, cnt_a);
    end
    // Four 100-cycle WAIT_DONE stints, three one-cycle re-ISSUEs, plus the acceptance edge.
    n_vec++;
    if (cyc - t_acc1 != 4 * TMO + 4) begin
      n_miss++; $display("FAIL wdog_time: got %0d want %0d", cyc - t_acc1, 4 * TMO + 4);
    end
  endtask
`endif

  initial begin
    start_a = 1'b0;
    start_b = 1'b0;
    clear_stats();
    load_rom_std();
    for (int i = 0; i < 4; i++) rom_b[i] = 16'hFFFF;
    test_reset();
    test_basic();
    test_ready_stall();
    test_retry_recover();
    test_retry_exhaust();
    test_reset_mid_pass();
    test_no_end_marker();
`ifdef SCCB_CFG_WATCHDOG_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
